// File: rtl/arp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arp_pkg
// Description : Shared constants, header offsets and parser state encoding
//               for the ARP receive engine and its IP->MAC cache.
// Revision    : 1.0 - initial release
// ============================================================================
package arp_pkg;

  // ARP opcodes
  localparam logic [15:0] ARP_REQUEST_CODE = 16'd1;
  localparam logic [15:0] ARP_REPLY_CODE   = 16'd2;

  // Fixed header values for Ethernet / IPv4 ARP
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;

  // Byte offsets of the header fields, MSB first
  localparam int OFF_HTYPE = 0;
  localparam int OFF_PTYPE = 2;
  localparam int OFF_HLEN  = 4;
  localparam int OFF_PLEN  = 5;
  localparam int OFF_OPER  = 6;
  localparam int OFF_SHA   = 8;
  localparam int OFF_SPA   = 14;
  localparam int OFF_THA   = 18;
  localparam int OFF_TPA   = 24;

  // Bytes actually stored; everything beyond is padding
  localparam int HDR_BYTES = 28;
  localparam int HDR_IDX_W = 5;

  // One-hot parser states
  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_REC      = 4'b0010,
    ST_WAIT_CRC = 4'b0100,
    ST_COMMIT   = 4'b1000
  } arp_state_t;

  // True when the fixed part of the header describes Ethernet/IPv4 ARP
  function automatic logic arp_hdr_ok(input logic [15:0] htype,
                                      input logic [15:0] ptype,
                                      input logic [7:0]  hlen,
                                      input logic [7:0]  plen);
    return (htype == ARP_HTYPE_ETH) && (ptype == ARP_PTYPE_IPV4) &&
           (hlen == ARP_HLEN_ETH) && (plen == ARP_PLEN_IPV4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arp_cache.sv
`default_nettype none
// ============================================================================
// Module      : arp_cache
// Description : IP->MAC binding table with parallel IP match, in-place
//               update, lowest-free allocation, round-robin eviction, flush
//               and a registered lookup port.
// Revision    : 1.0 - initial release
// ============================================================================
module arp_cache
  import arp_pkg::*;
#(
  parameter int CACHE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_ip,
  input  logic [47:0] wr_mac,
  input  logic        lookup_req,
  input  logic [31:0] lookup_ip,
  output logic        lookup_done,
  output logic        lookup_hit,
  output logic [47:0] lookup_mac
);

  localparam int IDX_W = $clog2(CACHE_DEPTH);

  logic [CACHE_DEPTH-1:0] ent_valid;
  logic [31:0]            ent_ip  [CACHE_DEPTH];
  logic [47:0]            ent_mac [CACHE_DEPTH];
  logic [IDX_W-1:0]       victim;

  logic             wr_hit;
  logic [IDX_W-1:0] wr_hit_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             use_victim;
  logic             lk_hit;
  logic [47:0]      lk_mac;

  // Slot selection: same-IP entry first, then lowest free slot, then victim
  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_idx = '0;
    free_found = 1'b0;
    free_idx   = '0;
    wr_idx     = victim;
    use_victim = 1'b0;
    // Walk downwards so the lowest matching index is the one kept
    for (int i = CACHE_DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ent_valid[i] && (ent_ip[i] == wr_ip)) begin
        wr_hit     = 1'b1;
        wr_hit_idx = IDX_W'(i);
      end
    end
    if (wr_hit) begin
      wr_idx = wr_hit_idx;
    end else if (free_found) begin
      wr_idx = free_idx;
    end else begin
      wr_idx     = victim;
      use_victim = 1'b1;
    end
  end

  // Parallel lookup match against the current (pre-write) contents
  always_comb begin
    lk_hit = 1'b0;
    lk_mac = '0;
    for (int i = 0; i < CACHE_DEPTH; i++) begin
      if (ent_valid[i] && (ent_ip[i] == lookup_ip)) begin
        lk_hit = 1'b1;
        lk_mac = ent_mac[i];
      end
    end
  end

  // Valid bits and victim pointer; a flush overrides a concurrent write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      victim    <= '0;
    end else if (flush) begin
      ent_valid <= '0;
      victim    <= '0;
    end else if (wr_en) begin
      ent_valid[wr_idx] <= 1'b1;
      if (use_victim) begin
        victim <= victim + 1'b1;
      end
    end
  end

  // Entry payload storage; contents are qualified by the valid bits
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      ent_ip[wr_idx]  <= wr_ip;
      ent_mac[wr_idx] <= wr_mac;
    end
  end

  // Registered lookup response, one cycle after the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookup_done <= 1'b0;
      lookup_hit  <= 1'b0;
      lookup_mac  <= '0;
    end else begin
      lookup_done <= lookup_req;
      lookup_hit  <= lookup_req & lk_hit;
      lookup_mac  <= lookup_req ? lk_mac : 48'd0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/arp_rx_cache.sv
`default_nettype none
// ============================================================================
// Module      : arp_rx_cache
// Description : ARP receive parser. Captures the header from the payload
//               byte stream, validates it against the FCS verdict, raises
//               reply requests, reports replies to us and learns sender
//               bindings into the attached IP->MAC cache.
// Revision    : 1.0 - initial release
// ============================================================================
module arp_rx_cache
  import arp_pkg::*;
#(
  parameter int CACHE_DEPTH = 4,
  parameter int RX_BYTES    = 46,
  parameter int CRC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] local_ip_addr,
  input  logic [47:0] local_mac_addr,
  input  logic        arp_rx_req,
  input  logic        arp_rx_valid,
  input  logic [7:0]  arp_rx_data,
  input  logic        frame_done,
  input  logic        crc_error,
  output logic        arp_rx_end,
  output logic        arp_reply_req,
  input  logic        arp_reply_ack,
  output logic [31:0] arp_rec_source_ip_addr,
  output logic [47:0] arp_rec_source_mac_addr,
  output logic        arp_found,
  input  logic        lookup_req,
  input  logic [31:0] lookup_ip,
  output logic        lookup_done,
  output logic        lookup_hit,
  output logic [47:0] lookup_mac,
  input  logic        cache_flush
);

  localparam int CNT_W = $clog2(RX_BYTES + 1);
  localparam int TMO_W = $clog2(CRC_TIMEOUT + 1);

  arp_state_t       state, state_next;
  logic [CNT_W-1:0] byte_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             crc_err_q;
  logic [7:0]       hdr [HDR_BYTES];

  logic accept, last_byte, tmo_hit;
  logic commit, frame_ok, do_req, do_found, cache_wr;

  logic [15:0] f_htype, f_ptype, f_oper;
  logic [7:0]  f_hlen, f_plen;
  logic [47:0] f_sha, f_tha;
  logic [31:0] f_spa, f_tpa;

  // A restart or a short-frame drop takes priority over byte acceptance
  assign accept    = (state == ST_REC) && arp_rx_valid && !arp_rx_req && !frame_done;
  assign last_byte = accept && (byte_cnt == CNT_W'(RX_BYTES - 1));
  assign tmo_hit   = (state == ST_WAIT_CRC) && !frame_done &&
                     (tmo_cnt == TMO_W'(CRC_TIMEOUT - 1));

  assign f_htype = {hdr[OFF_HTYPE], hdr[OFF_HTYPE+1]};
  assign f_ptype = {hdr[OFF_PTYPE], hdr[OFF_PTYPE+1]};
  assign f_hlen  = hdr[OFF_HLEN];
  assign f_plen  = hdr[OFF_PLEN];
  assign f_oper  = {hdr[OFF_OPER], hdr[OFF_OPER+1]};
  assign f_sha   = {hdr[OFF_SHA], hdr[OFF_SHA+1], hdr[OFF_SHA+2],
                    hdr[OFF_SHA+3], hdr[OFF_SHA+4], hdr[OFF_SHA+5]};
  assign f_spa   = {hdr[OFF_SPA], hdr[OFF_SPA+1], hdr[OFF_SPA+2], hdr[OFF_SPA+3]};
  assign f_tha   = {hdr[OFF_THA], hdr[OFF_THA+1], hdr[OFF_THA+2],
                    hdr[OFF_THA+3], hdr[OFF_THA+4], hdr[OFF_THA+5]};
  assign f_tpa   = {hdr[OFF_TPA], hdr[OFF_TPA+1], hdr[OFF_TPA+2], hdr[OFF_TPA+3]};

  // A restart request in COMMIT aborts that frame like in any other state
  assign commit   = (state == ST_COMMIT) && !arp_rx_req;
  assign frame_ok = !crc_err_q &&
                    arp_hdr_ok(f_htype, f_ptype, f_hlen, f_plen) &&
                    ((f_oper == ARP_REQUEST_CODE) || (f_oper == ARP_REPLY_CODE)) &&
                    (f_tpa == local_ip_addr);
  assign do_req   = commit && frame_ok && (f_oper == ARP_REQUEST_CODE) && !arp_reply_req;
  assign do_found = commit && frame_ok && (f_oper == ARP_REPLY_CODE) &&
                    (f_tha == local_mac_addr);
  assign cache_wr = commit && frame_ok;

  // Parser next-state decision
  always_comb begin
    state_next = state;
    if (arp_rx_req) begin
      state_next = ST_REC;
    end else begin
      unique case (state)
        ST_IDLE:     state_next = ST_IDLE;
        ST_REC: begin
          if (frame_done)     state_next = ST_IDLE;
          else if (last_byte) state_next = ST_WAIT_CRC;
        end
        ST_WAIT_CRC: begin
          if (frame_done)   state_next = ST_COMMIT;
          else if (tmo_hit) state_next = ST_IDLE;
        end
        ST_COMMIT:   state_next = ST_IDLE;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  // Parser state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Byte counter, CRC wait timer, latched FCS verdict and end-of-count pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= '0;
      tmo_cnt    <= '0;
      crc_err_q  <= 1'b0;
      arp_rx_end <= 1'b0;
    end else begin
      if (arp_rx_req)  byte_cnt <= '0;
      else if (accept) byte_cnt <= byte_cnt + 1'b1;

      if ((state == ST_WAIT_CRC) && (state_next == ST_WAIT_CRC)) tmo_cnt <= tmo_cnt + 1'b1;
      else                                                        tmo_cnt <= '0;

      if ((state == ST_WAIT_CRC) && frame_done) crc_err_q <= crc_error;

      arp_rx_end <= last_byte;
    end
  end

  // Header byte capture by offset; padding bytes are not stored
  always_ff @(posedge clk) begin
    if (accept && (byte_cnt < CNT_W'(HDR_BYTES))) begin
      hdr[byte_cnt[HDR_IDX_W-1:0]] <= arp_rx_data;
    end
  end

  // Commit results: reply request with frozen sender, and reply-to-us pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arp_reply_req           <= 1'b0;
      arp_rec_source_ip_addr  <= '0;
      arp_rec_source_mac_addr <= '0;
      arp_found               <= 1'b0;
    end else begin
      if (do_req) begin
        arp_reply_req           <= 1'b1;
        arp_rec_source_ip_addr  <= f_spa;
        arp_rec_source_mac_addr <= f_sha;
      end else if (arp_reply_ack) begin
        arp_reply_req <= 1'b0;
      end
      arp_found <= do_found;
    end
  end

  arp_cache #(
    .CACHE_DEPTH (CACHE_DEPTH)
  ) u_cache (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (cache_flush),
    .wr_en       (cache_wr),
    .wr_ip       (f_spa),
    .wr_mac      (f_sha),
    .lookup_req  (lookup_req),
    .lookup_ip   (lookup_ip),
    .lookup_done (lookup_done),
    .lookup_hit  (lookup_hit),
    .lookup_mac  (lookup_mac)
  );

endmodule
`default_nettype wire

// File: tb/tb_arp_rx_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_arp_rx_cache
// Description : Randomised scoreboard bench for arp_rx_cache with a
//               behavioural IP->MAC table and reply-request model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arp_rx_cache;

  localparam int          RXB   = 46;
  localparam int          TMO   = 64;
  localparam int          DEPTH = 4;
  localparam logic [31:0] LIP   = 32'hC0A80002;
  localparam logic [47:0] LMAC  = 48'h000A3501FEC0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arp_rx_req = 0, arp_rx_valid = 0, frame_done = 0, crc_error = 0;
  logic [7:0]  arp_rx_data = 0;
  logic        arp_reply_ack = 0, lookup_req = 0, cache_flush = 0;
  logic [31:0] lookup_ip = 0;
  logic        arp_rx_end, arp_reply_req, arp_found, lookup_done, lookup_hit;
  logic [31:0] arp_rec_source_ip_addr;
  logic [47:0] arp_rec_source_mac_addr, lookup_mac;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  arp_rx_cache #(.CACHE_DEPTH(DEPTH), .RX_BYTES(RXB), .CRC_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .local_ip_addr(LIP), .local_mac_addr(LMAC),
    .arp_rx_req(arp_rx_req), .arp_rx_valid(arp_rx_valid), .arp_rx_data(arp_rx_data),
    .frame_done(frame_done), .crc_error(crc_error),
    .arp_rx_end(arp_rx_end), .arp_reply_req(arp_reply_req), .arp_reply_ack(arp_reply_ack),
    .arp_rec_source_ip_addr(arp_rec_source_ip_addr),
    .arp_rec_source_mac_addr(arp_rec_source_mac_addr),
    .arp_found(arp_found),
    .lookup_req(lookup_req), .lookup_ip(lookup_ip),
    .lookup_done(lookup_done), .lookup_hit(lookup_hit), .lookup_mac(lookup_mac),
    .cache_flush(cache_flush)
  );

  // ---------------- scoreboard queues ----------------
  typedef struct { int cyc; logic [31:0] ip; logic [47:0] mac; } rise_t;
  typedef struct { int cyc; logic hit; logic [47:0] mac; } lk_t;
  int    end_q[$];
  int    found_q[$];
  int    fall_q[$];
  rise_t rise_q[$];
  lk_t   lk_q[$];
  logic [31:0] exp_src_ip  = 0;
  logic [47:0] exp_src_mac = 0;

  // ---------------- behavioural model ----------------
  bit          m_v   [DEPTH];
  logic [31:0] m_ip  [DEPTH];
  logic [47:0] m_mac [DEPTH];
  int          m_victim = 0;
  bit          m_req = 0;

  function automatic void m_clear();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
    m_victim = 0;
  endfunction

  function automatic void m_learn(input logic [31:0] ip, input logic [47:0] mac);
    int slot = -1;
    for (int i = 0; i < DEPTH; i++) if (m_v[i] && m_ip[i] == ip) slot = i;
    if (slot < 0) for (int i = 0; i < DEPTH; i++) if (!m_v[i] && slot < 0) slot = i;
    if (slot < 0) begin
      slot = m_victim;
      m_victim = (m_victim + 1) % DEPTH;
    end
    m_v[slot] = 1; m_ip[slot] = ip; m_mac[slot] = mac;
  endfunction

  // ---------------- monitor ----------------
  logic  prev_req = 0;
  int    e_pop;
  rise_t r_pop;
  lk_t   l_pop;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 0;
    end else begin
      if (arp_rx_end) begin
        checks++;
        if (end_q.size() == 0) begin
          errors++; $display("FAIL rx_end: unexpected pulse at cycle %0d, required none", cyc);
        end else begin
          e_pop = end_q.pop_front();
          if (e_pop != cyc) begin
            errors++; $display("FAIL rx_end: pulse at cycle %0d, required %0d", cyc, e_pop);
          end
        end
      end
      if (arp_found) begin
        checks++;
        if (found_q.size() == 0) begin
          errors++; $display("FAIL arp_found: unexpected pulse at cycle %0d, required none", cyc);
        end else begin
          e_pop = found_q.pop_front();
          if (e_pop != cyc) begin
            errors++; $display("FAIL arp_found: pulse at cycle %0d, required %0d", cyc, e_pop);
          end
        end
      end
      if (lookup_done) begin
        checks++;
        if (lk_q.size() == 0) begin
          errors++; $display("FAIL lookup: unexpected done at cycle %0d", cyc);
        end else begin
          l_pop = lk_q.pop_front();
          if (l_pop.cyc != cyc || l_pop.hit !== lookup_hit || l_pop.mac !== lookup_mac) begin
            errors++;
            $display("FAIL lookup: cyc %0d hit %0b mac %h, required cyc %0d hit %0b mac %h",
                     cyc, lookup_hit, lookup_mac, l_pop.cyc, l_pop.hit, l_pop.mac);
          end
        end
      end
      if (arp_reply_req && !prev_req) begin
        checks++;
        if (rise_q.size() == 0) begin
          errors++; $display("FAIL reply_req rise: unexpected at cycle %0d", cyc);
        end else begin
          r_pop = rise_q.pop_front();
          if (r_pop.cyc != cyc || r_pop.ip !== arp_rec_source_ip_addr ||
              r_pop.mac !== arp_rec_source_mac_addr) begin
            errors++;
            $display("FAIL reply_req rise: cyc %0d ip %h mac %h, required cyc %0d ip %h mac %h",
                     cyc, arp_rec_source_ip_addr, arp_rec_source_mac_addr,
                     r_pop.cyc, r_pop.ip, r_pop.mac);
          end
        end
      end
      if (!arp_reply_req && prev_req) begin
        checks++;
        if (fall_q.size() == 0) begin
          errors++; $display("FAIL reply_req fall: unexpected at cycle %0d", cyc);
        end else begin
          e_pop = fall_q.pop_front();
          if (e_pop != cyc || exp_src_ip !== arp_rec_source_ip_addr ||
              exp_src_mac !== arp_rec_source_mac_addr) begin
            errors++;
            $display("FAIL reply_req fall: cyc %0d ip %h mac %h, required cyc %0d ip %h mac %h",
                     cyc, arp_rec_source_ip_addr, arp_rec_source_mac_addr,
                     e_pop, exp_src_ip, exp_src_mac);
          end
        end
      end
      prev_req = arp_reply_req;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0]  fr [RXB];
  logic [15:0] f_oper, f_ptype;
  logic [7:0]  f_hlen;
  logic [47:0] f_smac, f_tmac;
  logic [31:0] f_sip, f_tip;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [47:0] rand48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[47:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic build(input logic [15:0] oper, input logic [47:0] smac, input logic [31:0] sip,
                       input logic [47:0] tmac, input logic [31:0] tip,
                       input logic [15:0] ptype, input logic [7:0] hlen);
    f_oper = oper; f_smac = smac; f_sip = sip; f_tmac = tmac; f_tip = tip;
    f_ptype = ptype; f_hlen = hlen;
    fr[0] = 8'h00; fr[1] = 8'h01;
    fr[2] = ptype[15:8]; fr[3] = ptype[7:0];
    fr[4] = hlen; fr[5] = 8'd4;
    fr[6] = oper[15:8]; fr[7] = oper[7:0];
    for (int i = 0; i < 6; i++) fr[8 + i]  = smac[47 - 8*i -: 8];
    for (int i = 0; i < 4; i++) fr[14 + i] = sip[31 - 8*i -: 8];
    for (int i = 0; i < 6; i++) fr[18 + i] = tmac[47 - 8*i -: 8];
    for (int i = 0; i < 4; i++) fr[24 + i] = tip[31 - 8*i -: 8];
    for (int i = 28; i < RXB; i++) fr[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic start_frame();
    arp_rx_req = 1; tick(); arp_rx_req = 0;
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        arp_rx_valid = 0; arp_rx_data = 8'($urandom_range(0, 255)); tick();
      end
      arp_rx_valid = 1; arp_rx_data = fr[i];
      if (i == RXB - 1) end_q.push_back(cyc + 1);
      tick();
    end
    arp_rx_valid = 0;
  endtask

  // mode: 0 full frame, 1 no frame_done (timeout), 2 short frame, 3 restart mid-REC
  task automatic run_frame(input bit crc, input int mode, input bit flush_at_commit);
    int  f;
    bit  ok;
    start_frame();
    if (mode == 2) begin
      send_bytes(20);
      frame_done = 1; tick(); frame_done = 0;
      repeat (3) tick();
      return;
    end
    if (mode == 3) begin
      send_bytes(10);
      start_frame();
    end
    send_bytes(RXB);
    if (mode == 1) begin
      repeat (TMO + 6) tick();
      frame_done = 1; tick(); frame_done = 0;
      repeat (4) tick();
      return;
    end
    repeat ($urandom_range(0, 10)) tick();
    frame_done = 1; crc_error = crc; f = cyc; tick();
    frame_done = 0; crc_error = 0;
    if (flush_at_commit) begin
      cache_flush = 1; tick(); cache_flush = 0;
    end
    ok = !crc && f_ptype == 16'h0800 && f_hlen == 8'd6 &&
         (f_oper == 16'd1 || f_oper == 16'd2) && f_tip == LIP;
    if (ok && f_oper == 16'd1 && !m_req) begin
      m_req = 1;
      rise_q.push_back('{cyc: f + 2, ip: f_sip, mac: f_smac});
      exp_src_ip = f_sip; exp_src_mac = f_smac;
    end
    if (ok && f_oper == 16'd2 && f_tmac == LMAC) found_q.push_back(f + 2);
    if (flush_at_commit) m_clear();
    else if (ok)         m_learn(f_sip, f_smac);
    repeat (3) tick();
  endtask

  task automatic lookup(input logic [31:0] ip);
    lk_t e;
    e.cyc = cyc + 1; e.hit = 0; e.mac = '0;
    for (int i = 0; i < DEPTH; i++)
      if (m_v[i] && m_ip[i] == ip) begin e.hit = 1; e.mac = m_mac[i]; end
    lk_q.push_back(e);
    lookup_req = 1; lookup_ip = ip; tick(); lookup_req = 0;
  endtask

  task automatic ack();
    if (m_req) fall_q.push_back(cyc + 1);
    m_req = 0;
    arp_reply_ack = 1; tick(); arp_reply_ack = 0; tick();
  endtask

  task automatic flush();
    cache_flush = 1; tick(); cache_flush = 0; m_clear(); tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset arp_rx_end", 64'(arp_rx_end), 64'd0);
    chk("reset arp_reply_req", 64'(arp_reply_req), 64'd0);
    chk("reset source_ip", 64'(arp_rec_source_ip_addr), 64'd0);
    chk("reset source_mac", 64'(arp_rec_source_mac_addr), 64'd0);
    chk("reset arp_found", 64'(arp_found), 64'd0);
    chk("reset lookup_done", 64'(lookup_done), 64'd0);
    chk("reset lookup_hit", 64'(lookup_hit), 64'd0);
    chk("reset lookup_mac", 64'(lookup_mac), 64'd0);
    rst_n = 1;
    tick(); tick();
    lookup(32'hC0A80001);

    // Reply request, then ack
    build(16'd1, 48'h112233445566, 32'hC0A80001, 48'h0, LIP, 16'h0800, 8'd6);
    run_frame(0, 0, 0);
    ack();

    // CRC error and bad ptype: nothing learned, no request
    flush();
    build(16'd1, 48'h112233445566, 32'hC0A80001, 48'h0, LIP, 16'h0800, 8'd6);
    run_frame(1, 0, 0);
    build(16'd1, 48'h112233445566, 32'hC0A80001, 48'h0, LIP, 16'h86DD, 8'd6);
    run_frame(0, 0, 0);
    lookup(32'hC0A80001);

    // Reply learning
    build(16'd2, 48'hAABBCCDDEEFF, 32'hC0A80005, LMAC, LIP, 16'h0800, 8'd6);
    run_frame(0, 0, 0);
    lookup(32'hC0A80005);

    // Replacement
    flush();
    for (int k = 1; k <= 5; k++) begin
      build(16'd2, rand48(), 32'hC0A80000 + 32'(k), 48'h0000_1111_2222, LIP, 16'h0800, 8'd6);
      run_frame(0, 0, 0);
    end
    lookup(32'hC0A80001);
    lookup(32'hC0A80002);
    build(16'd2, 48'h0123456789AB, 32'hC0A80003, 48'h0000_1111_2222, LIP, 16'h0800, 8'd6);
    run_frame(0, 0, 0);
    lookup(32'hC0A80003);
    lookup(32'hC0A80002);
    lookup(32'hC0A80005);

    // Pending reply keeps its sender; restart mid-REC parses from byte 0
    build(16'd1, 48'h0A0A0A0A0A07, 32'hC0A80007, 48'h0, LIP, 16'h0800, 8'd6);
    run_frame(0, 0, 0);
    build(16'd1, 48'h0B0B0B0B0B08, 32'hC0A80008, 48'h0, LIP, 16'h0800, 8'd6);
    run_frame(0, 0, 0);
    ack();
    build(16'd1, 48'h0C0C0C0C0C09, 32'hC0A80009, 48'h0, LIP, 16'h0800, 8'd6);
    run_frame(0, 3, 0);
    lookup(32'hC0A80009);
    ack();

    // Timeout, then flush coinciding with a commit
    build(16'd1, 48'h0D0D0D0D0D0A, 32'hC0A8000A, 48'h0, LIP, 16'h0800, 8'd6);
    run_frame(0, 1, 0);
    lookup(32'hC0A8000A);
    build(16'd2, 48'h0E0E0E0E0E0B, 32'hC0A8000B, LMAC, LIP, 16'h0800, 8'd6);
    run_frame(0, 0, 1);
    lookup(32'hC0A8000B);
    lookup(32'hC0A80009);
    lookup(32'hC0A80003);

    // Randomised traffic
    for (int k = 0; k < 40; k++) begin
      logic [15:0] op;
      int r, mode;
      r = $urandom_range(0, 9);
      op = (r < 4) ? 16'd1 : (r < 8) ? 16'd2 : 16'($urandom_range(3, 65535));
      build(op, rand48(), 32'hC0A80010 + 32'($urandom_range(0, 6)),
            ($urandom_range(0, 1) == 0) ? LMAC : rand48(),
            ($urandom_range(0, 4) == 0) ? $urandom : LIP,
            ($urandom_range(0, 7) == 0) ? 16'h86DD : 16'h0800,
            ($urandom_range(0, 7) == 0) ? 8'd8 : 8'd6);
      r = $urandom_range(0, 9);
      mode = (r == 0) ? 2 : (r == 1) ? 3 : 0;
      run_frame($urandom_range(0, 5) == 0, mode, $urandom_range(0, 11) == 0);
      repeat (2) lookup(32'hC0A80010 + 32'($urandom_range(0, 6)));
      if ($urandom_range(0, 1) == 0) ack();
    end
    ack();

    // Reset in the middle of a frame: nothing committed, cache empty
    build(16'd1, 48'h0F0F0F0F0F0C, 32'hC0A8000C, 48'h0, LIP, 16'h0800, 8'd6);
    start_frame();
    send_bytes(30);
    rst_n = 0; tick(); tick(); rst_n = 1;
    m_clear();
    frame_done = 1; tick(); frame_done = 0;
    repeat (3) tick();
    lookup(32'hC0A8000C);
    lookup(32'hC0A80010);

    repeat (10) tick();
    chk("rx_end queue drained", 64'(end_q.size()), 64'd0);
    chk("found queue drained", 64'(found_q.size()), 64'd0);
    chk("rise queue drained", 64'(rise_q.size()), 64'd0);
    chk("fall queue drained", 64'(fall_q.size()), 64'd0);
    chk("lookup queue drained", 64'(lk_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
